regfile_multi: RTL and testbench

- Parametrised successor to the 8-entry, 2-write / 2-read pipeline register file.
- Provides configurable data width, register count and address width.
- Read ports are registered, with a hold (stall) control.
- Write-port collisions are resolved deterministically, and each register carries a written-since-clear (dirty) flag.
- Sits between the decode and write-back stages of the pipelined core; the full register image is exported for the debug/trace logic.

---
 rtl/regfile_multi.sv | 113 +++++++++++
 tb/tb_regfile_multi.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_multi.sv
// Parametrised 2-write / 2-read register file with registered, stallable read
// ports and per-register dirty flags. Define REGFILE_MULTI_BYPASS_EN to forward
// same-edge writes into the read registers.
module regfile_multi #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          dstE,
  input  logic [DATA_W-1:0]          valE,
  input  logic [ADDR_W-1:0]          dstM,
  input  logic [DATA_W-1:0]          valM,
  input  logic [ADDR_W-1:0]          rA,
  input  logic [ADDR_W-1:0]          rB,
  input  logic                       stall,
  input  logic                       clr_dirty,
  output logic [DATA_W-1:0]          valA,
  output logic [DATA_W-1:0]          valB,
  output logic                       validA,
  output logic                       validB,
  output logic [NUM_REGS-1:0]        dirty,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

  // The all-ones ID is reserved as "no register", so it must never index storage.
  if (NUM_REGS < 2 || NUM_REGS >= (1 << ADDR_W)) begin : g_bad_cfg
    $error("regfile_multi: NUM_REGS must be in 2..(2**ADDR_W)-1");
  end

  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic [DATA_W-1:0]   valA_q, valA_d, valB_q, valB_d;
  logic                validA_q, validA_d, validB_q, validB_d;
  logic [DATA_W-1:0]   rd_a, rd_b;
  logic                we_e, we_m;

  assign we_e = (dstE < NUM_REGS_A);
  assign we_m = (dstM < NUM_REGS_A);

  // Port M is applied after port E so it wins a collision with a single write.
  always_comb begin
    regs_d  = regs_q;
    dirty_d = clr_dirty ? '0 : dirty_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (we_e && dstE == ADDR_W'(i)) begin
        regs_d[i]  = valE;
        dirty_d[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (we_m && dstM == ADDR_W'(i)) begin
        regs_d[i]  = valM;
        dirty_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rA == ADDR_W'(i)) rd_a = regs_q[i];
      if (rB == ADDR_W'(i)) rd_b = regs_q[i];
    end
`ifdef REGFILE_MULTI_BYPASS_EN
    if (we_e && rA == dstE) rd_a = valE;
    if (we_m && rA == dstM) rd_a = valM;
    if (we_e && rB == dstE) rd_b = valE;
    if (we_m && rB == dstM) rd_b = valM;
`endif
  end

  always_comb begin
    valA_d   = stall ? valA_q   : rd_a;
    valB_d   = stall ? valB_q   : rd_b;
    validA_d = stall ? validA_q : (rA < NUM_REGS_A);
    validB_d = stall ? validB_q : (rB < NUM_REGS_A);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      dirty_q  <= '0;
      valA_q   <= '0;
      valB_q   <= '0;
      validA_q <= 1'b0;
      validB_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      dirty_q  <= dirty_d;
      valA_q   <= valA_d;
      valB_q   <= valB_d;
      validA_q <= validA_d;
      validB_q <= validB_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign valA   = valA_q;
  assign valB   = valB_q;
  assign validA = validA_q;
  assign validB = validB_q;
  assign dirty  = dirty_q;

endmodule

// File: tb/tb_regfile_multi.sv
// Self-checking bench for regfile_multi at default parameters; honours
// REGFILE_MULTI_BYPASS_EN in its reference model.
module tb_regfile_multi;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 4;

  logic          clock, reset;
  logic [AW-1:0] dstE, dstM, rA, rB;
  logic [DW-1:0] valE, valM;
  logic          stall, clr_dirty;
  logic [DW-1:0] valA, valB;
  logic          validA, validB;
  logic [NR-1:0] dirty;
  logic [NR*DW-1:0] regs_flat;

  regfile_multi #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .rA(rA), .rB(rB), .stall(stall), .clr_dirty(clr_dirty),
    .valA(valA), .valB(valB), .validA(validA), .validB(validB),
    .dirty(dirty), .regs_flat(regs_flat)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model and scoreboard
  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_dirty;
  logic [2*DW+1:0] last_exp;
  logic [2*DW+1:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_dirty  = '0;
    last_exp = '0;
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] r,
      input logic [AW-1:0] de, input logic [DW-1:0] ve,
      input logic [AW-1:0] dm, input logic [DW-1:0] vm);
    logic [DW-1:0] v;
    v = (r < NR) ? m_regs[r[2:0]] : '0;
`ifdef REGFILE_MULTI_BYPASS_EN
    if (de < NR && r == de) v = ve;
    if (dm < NR && r == dm) v = vm;
`endif
    return v;
  endfunction

  // driver: one clock cycle of stimulus, then check what the DUT produced
  task automatic step(input logic [AW-1:0] de, input logic [DW-1:0] ve,
      input logic [AW-1:0] dm, input logic [DW-1:0] vm,
      input logic [AW-1:0] ra, input logic [AW-1:0] rb,
      input logic st, input logic clr);
    logic [2*DW+1:0] e, got;
    @(negedge clock);
    dstE = de; valE = ve; dstM = dm; valM = vm;
    rA = ra; rB = rb; stall = st; clr_dirty = clr;
    if (st) e = last_exp;
    else e = {ra < NR, model_read(ra, de, ve, dm, vm), rb < NR, model_read(rb, de, ve, dm, vm)};
    exp_q.push_back(e);
    last_exp = e;
    if (clr) m_dirty = '0;
    if (de < NR) begin m_regs[de[2:0]] = ve; m_dirty[de[2:0]] = 1'b1; end
    if (dm < NR) begin m_regs[dm[2:0]] = vm; m_dirty[dm[2:0]] = 1'b1; end
    @(posedge clock);
    #1;
    got = {validA, valA, validB, valB};
    if (exp_q.size() == 0) check_eq("sb_empty", 1, 0);
    else check_eq("read_ports", got, exp_q.pop_front());
    check_eq("dirty", dirty, m_dirty);
    check_eq("regs_flat", regs_flat, model_flat());
  endtask

  task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic st);
    step(4'hF, '0, 4'hF, '0, ra, rb, st, 1'b0);
  endtask

  logic [NR*DW-1:0] snap_flat;
  logic [NR-1:0]    snap_dirty;

  initial begin
    reset = 1'b1;
    dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
    rA = 4'hF; rB = 4'hF; stall = 1'b0; clr_dirty = 1'b0;
    model_reset();
    #12;
    check_eq("reset_rd", {validA, valA, validB, valB}, '0);
    check_eq("reset_dirty", dirty, '0);
    check_eq("reset_flat", regs_flat, '0);
    @(negedge clock);
    reset = 1'b0;

    // basic two-port write then read
    step(4'd0, 32'hABCDEF98, 4'd1, 32'h7654321A, 4'hF, 4'hF, 1'b0, 1'b0);
    idle(4'd0, 4'd1, 1'b0);
    check_eq("basic_valA", valA, 32'hABCDEF98);
    check_eq("basic_valB", valB, 32'h7654321A);
    check_eq("basic_valid", {validA, validB}, 2'b11);
    check_eq("basic_dirty", dirty, 8'b0000_0011);

    // collision: M wins
    step(4'd3, 32'h11111111, 4'd3, 32'h22222222, 4'hF, 4'hF, 1'b0, 1'b0);
    idle(4'd3, 4'hF, 1'b0);
    check_eq("coll_valA", valA, 32'h22222222);
    check_eq("coll_dirty3", dirty[3], 1'b1);

    // illegal IDs ignored
    snap_flat = regs_flat; snap_dirty = dirty;
    step(4'hF, 32'h55555555, 4'd9, 32'h66666666, 4'hF, 4'd0, 1'b0, 1'b0);
    check_eq("illegal_flat", regs_flat, snap_flat);
    check_eq("illegal_dirty", dirty, snap_dirty);
    check_eq("illegal_rd", {validA, valA}, '0);

    // stall holds read ports while writes proceed
    step(4'd2, 32'h5, 4'hF, '0, 4'hF, 4'hF, 1'b0, 1'b0);
    idle(4'd2, 4'd2, 1'b0);
    check_eq("stall_pre", valA, 32'h5);
    step(4'd2, 32'h9, 4'hF, '0, 4'd0, 4'd0, 1'b1, 1'b0);
    check_eq("stall_hold1", valA, 32'h5);
    idle(4'd0, 4'd2, 1'b1);
    check_eq("stall_hold2", valA, 32'h5);
    idle(4'd0, 4'd2, 1'b0);
    check_eq("stall_rel_A", valA, 32'hABCDEF98);
    check_eq("stall_rel_B", valB, 32'h9);

    // clr_dirty with a write: set beats clear
    step(4'd5, 32'h77, 4'hF, '0, 4'hF, 4'hF, 1'b0, 1'b1);
    check_eq("clr_dirty", dirty, 8'b0010_0000);

    // same-cycle read/write of reg 6
    step(4'd6, 32'hCAFE0000, 4'hF, '0, 4'd6, 4'hF, 1'b0, 1'b0);
`ifdef REGFILE_MULTI_BYPASS_EN
    check_eq("rw_same_A", valA, 32'hCAFE0000);
`else
    check_eq("rw_same_A", valA, 32'h0);
`endif

    // random traffic
    for (int k = 0; k < 60; k++) begin
      step(AW'($urandom_range(0, 15)), $urandom, AW'($urandom_range(0, 15)), $urandom,
           AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    // async reset while clock is high
    idle(4'd1, 4'd2, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check_eq("areset_rd", {validA, valA, validB, valB}, '0);
    check_eq("areset_dirty", dirty, '0);
    check_eq("areset_flat", regs_flat, '0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step(4'd4, 32'h0BADF00D, 4'hF, '0, 4'd4, 4'd7, 1'b0, 1'b0);
    idle(4'd4, 4'd7, 1'b0);
    check_eq("post_rst_valA", valA, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
